// File: rtl/fp_addmul_seq.sv
`default_nettype none
// ---- fp_addmul_seq: handshaked IEEE-754 single add/multiply, 5-state FSM, truncating -- rev 1.0 ----
module fp_addmul_seq #(
  parameter int LATENCY_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Float_num_A,
  input  logic [31:0] Float_num_B,
  input  logic        OP_input,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Resultado
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    EXEC  = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [31:0]        a_q, b_q;
  logic               op_q;
  logic               sign_q;
  logic               sub_q;
  logic               mzero_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        man_big_q, man_small_q;
  logic [47:0]        acc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ALIGN;
      end
      ALIGN: state_next = EXEC;
      EXEC:  state_next = NORM;
      NORM:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Unpack with zero/subnormal flush; for add, order operands by magnitude
  logic [7:0]  ea, eb, big_e, ediff;
  logic [23:0] ma, mb, big_m, small_m, small_sh;
  logic        a_nz, b_nz, a_ge_b;

  always_comb begin
    ea       = a_q[30:23];
    eb       = b_q[30:23];
    a_nz     = (ea != 8'd0);
    b_nz     = (eb != 8'd0);
    ma       = a_nz ? {1'b1, a_q[22:0]} : 24'd0;
    mb       = b_nz ? {1'b1, b_q[22:0]} : 24'd0;
    a_ge_b   = ({ea, ma} >= {eb, mb});
    if (a_ge_b) begin
      big_e   = ea;
      big_m   = ma;
      small_m = mb;
      ediff   = ea - eb;
    end else begin
      big_e   = eb;
      big_m   = mb;
      small_m = ma;
      ediff   = eb - ea;
    end
    small_sh = (ediff >= 8'd25) ? 24'd0 : (small_m >> ediff);
  end

  logic [24:0]       sum;
  logic [4:0]        lz;
  logic [22:0]       sum_sh, man_n;
  logic signed [9:0] exp_n;
  logic              res_zero;
  logic [31:0]       res_n;

  always_comb begin
    sum = acc_q[24:0];
    lz  = 5'd0;
    // Last hit wins, so lz ends up as the distance to the highest set bit
    for (int i = 0; i < 24; i++) begin
      if (sum[i]) lz = 5'(23 - i);
    end
    sum_sh   = sum[22:0] << lz;
    exp_n    = exp_q;
    man_n    = 23'd0;
    res_zero = 1'b0;
    if (op_q) begin
      res_zero = mzero_q;
      if (acc_q[47]) begin
        exp_n = exp_q + 10'sd1;
        man_n = acc_q[46:24];
      end else begin
        man_n = acc_q[45:23];
      end
    end else begin
      res_zero = (sum == 25'd0);
      if (sum[24]) begin
        exp_n = exp_q + 10'sd1;
        man_n = sum[23:1];
      end else begin
        exp_n = exp_q - $signed({5'd0, lz});
        man_n = sum_sh;
      end
    end
    if (res_zero)                res_n = {op_q & sign_q, 31'd0};
    else if (exp_n >= 10'sd255)  res_n = {sign_q, 8'hFF, 23'd0};
    else if (exp_n <= 10'sd0)    res_n = {sign_q, 31'd0};
    else                         res_n = {sign_q, exp_n[7:0], man_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 1'b0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      mzero_q     <= 1'b0;
      exp_q       <= 10'sd0;
      man_big_q   <= 24'd0;
      man_small_q <= 24'd0;
      acc_q       <= 48'd0;
      Resultado   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q  <= Float_num_A;
            b_q  <= Float_num_B;
            op_q <= OP_input;
          end
        end
        ALIGN: begin
          if (op_q) begin
            sign_q      <= a_q[31] ^ b_q[31];
            sub_q       <= 1'b0;
            mzero_q     <= !a_nz || !b_nz;
            exp_q       <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            man_big_q   <= ma;
            man_small_q <= mb;
          end else begin
            sign_q      <= a_ge_b ? a_q[31] : b_q[31];
            sub_q       <= a_q[31] ^ b_q[31];
            mzero_q     <= 1'b0;
            exp_q       <= $signed({2'b00, big_e});
            man_big_q   <= big_m;
            man_small_q <= small_sh;
          end
        end
        EXEC: begin
          if (op_q)
            acc_q <= {24'd0, man_big_q} * {24'd0, man_small_q};
          else if (sub_q)
            acc_q <= {23'd0, {1'b0, man_big_q} - {1'b0, man_small_q}};
          else
            acc_q <= {23'd0, {1'b0, man_big_q} + {1'b0, man_small_q}};
        end
        NORM:    Resultado <= res_n;
        default: ;
      endcase
    end
  end

  generate
    if (LATENCY_CHECK != 0) begin : g_latency_check
      logic [3:0] acc_pipe;
      logic       out_valid_d;
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_pipe    <= 4'd0;
          out_valid_d <= 1'b0;
        end else begin
          acc_pipe    <= {acc_pipe[2:0], in_valid && in_ready};
          out_valid_d <= out_valid;
          assert (acc_pipe[3] == (out_valid && !out_valid_d));
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fp_addmul_seq.sv
`default_nettype none
// Scoreboard bench for fp_addmul_seq: directed and random operands against a behavioural FP model.
module tb_fp_addmul_seq;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, op = 1'b0;
  logic        bp_en = 1'b0, dir_ready = 1'b1, rnd_ready = 1'b1;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        in_ready, out_valid, out_ready;
  logic [31:0] res;

  assign out_ready = bp_en ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  fp_addmul_seq #(.LATENCY_CHECK(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Float_num_A(a),
    .Float_num_B(b),
    .OP_input   (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Resultado  (res)
  );

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [31:0] exp_q[$];
  int          acc_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Truncating single-precision model: integer mantissas on the larger operand's grid
  function automatic logic [31:0] fp_ref(input logic [31:0] x, input logic [31:0] y, input logic mul);
    longint mx, my, mag, v, sm;
    int     ex, ey, e, sh;
    logic   s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 64'sd0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 64'sd0 : longint'({1'b1, y[22:0]});
    if (mul) begin
      s = x[31] ^ y[31];
      if (mx == 0 || my == 0) return {s, 31'd0};
      mag = (mx * my) >> 23;
      e   = ex + ey - 127;
    end else begin
      if (ex > ey || (ex == ey && mx >= my)) begin
        sh = ex - ey;
        sm = (sh >= 40) ? 64'sd0 : (my >> sh);
        e  = ex;
        v  = (x[31] ? -mx : mx) + (y[31] ? -sm : sm);
      end else begin
        sh = ey - ex;
        sm = (sh >= 40) ? 64'sd0 : (mx >> sh);
        e  = ey;
        v  = (y[31] ? -my : my) + (x[31] ? -sm : sm);
      end
      if (v == 0) return 32'd0;
      s   = (v < 0);
      mag = s ? -v : v;
    end
    while (mag >= (longint'(1) << 24)) begin mag = mag >> 1; e++; end
    while (mag <  (longint'(1) << 23)) begin mag = mag << 1; e--; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), mag[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [31:0] other);
    logic [31:0] r;
    int          k, e;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
    if (k == 0) begin
      r = {r[31], 31'd0};
    end else if (k == 1) begin
      r = {~other[31], other[30:0]};
    end else if (k <= 5) begin
      e = int'(other[30:23]) + $urandom_range(0, 6) - 3;
      if (e < 1)   e = 1;
      if (e > 254) e = 254;
      r[30:23] = 8'(e);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency, hold-under-backpressure and result checks
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_res = 32'd0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_cyc.delete();
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && !prev_v) begin
        if (acc_cyc.size() == 0) begin
          vectors++; errors++;
          $display("FAIL spurious_valid: out_valid rose with no accepted operation (cycle %0d)", cyc);
        end else begin
          check("latency", 32'(cyc - acc_cyc.pop_front()), 32'd4);
        end
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", res, prev_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_result: got %08h with empty scoreboard", res);
        end else begin
          check("result", res, exp_q.pop_front());
        end
      end
      prev_v   = out_valid;
      prev_r   = out_ready;
      prev_res = res;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic m, input logic [31:0] expect_v);
    int n;
    n = 0;
    a = x; b = y; op = m; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expect_v);
        break;
      end
      if (++n > 100) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(posedge clk); #1;
      if (++n > 300) begin
        fail_now("drain_timeout");
        exp_q.delete();
        break;
      end
    end
  endtask

  logic [31:0] da [11] = '{32'h40D60000, 32'hC0D60000, 32'h40D60000, 32'h40D60000, 32'h40AE6666,
                           32'hC0000000, 32'h00000000, 32'h00000000, 32'h7F000000, 32'h00800000,
                           32'h4B800000};
  logic [31:0] db [11] = '{32'h40770000, 32'hC0770000, 32'hC0770000, 32'hC0D60000, 32'h3F000000,
                           32'h40400000, 32'h40400000, 32'h00000000, 32'h7F000000, 32'h00800000,
                           32'h3F800000};
  logic        dop[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] dres[11] = '{32'h4128C000, 32'hC128C000, 32'h40350000, 32'h00000000, 32'h402E6666,
                            32'hC0C00000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h00000000,
                            32'h4B800000};

  initial begin
    logic [31:0] r0, x, y;
    logic        m;
    int          n;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", res, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      issue(da[i], db[i], dop[i], dres[i]);
      drain();
    end

    // Abort an operation while it sits in EXEC
    a = 32'h40D60000; b = 32'h40770000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Backpressure in DONE with a second pair waiting on the inputs
    dir_ready = 1'b0;
    issue(32'h40AE6666, 32'h3F000000, 1'b1, 32'h402E6666);
    a = 32'hC0000000; b = 32'h40400000; op = 1'b1; in_valid = 1'b1;
    exp_q.push_back(32'hC0C00000);
    n = 0;
    while (!out_valid) begin
      @(negedge clk);
      if (++n > 20) begin fail_now("bp_valid_timeout"); break; end
    end
    r0 = res;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", res, r0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 dir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("consume_out_valid", {31'd0, out_valid}, 32'd0);
    check("consume_in_ready", {31'd0, in_ready}, 32'd1);
    check("consume_result_kept", res, r0);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // Random operands with random consumer backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = rnd_fp(32'h3F800000 ^ ($urandom & 32'h07FFFFFF));
      y = rnd_fp(x);
      m = 1'($urandom_range(0, 1));
      issue(x, y, m, fp_ref(x, y, m));
    end
    drain();
    bp_en = 1'b0;
    dir_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
